// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral-side handshake receiver.
// State encoding and default geometry of the receive FIFO.
package periph_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACK_HI = 2'b01,
        STALL  = 2'b10
    } rx_state_t;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/per_fifo.sv
// Circular receive FIFO; head word shown combinationally.
// Full is judged before any same-cycle pop.
module per_fifo
    import periph_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk1,
    input  logic                     rst1,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk1) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/periph_rx_handshake.sv
// Peripheral receiver for the CPU four-phase send/ack handshake.
// send is synchronised into clk1; accepted words are queued.
module periph_rx_handshake
    import periph_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                     clk1,
    input  logic                     rst1,
    input  logic [1:0]               send,
    input  logic [DATA_W-1:0]        dado,
    output logic                     ack,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     stall,
    output logic [CNT_W-1:0]         rx_count
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   send_s;
    logic                   unused_send1;
    rx_state_t              state;
    logic                   full;
    logic                   empty;
    logic                   push;

    assign unused_send1 = send[1];
    assign send_s       = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], send[0]};
        end
    end

    // dado is bundled data: stable while send is high, so sampled raw
    assign push = send_s && !full &&
                  ((state == IDLE) || (state == STALL));

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            state    <= IDLE;
            ack      <= 1'b0;
            stall    <= 1'b0;
            rx_count <= '0;
        end else begin
            if (push) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (send_s && !full) begin
                        state <= ACK_HI;
                        ack   <= 1'b1;
                    end else if (send_s) begin
                        state <= STALL;
                        stall <= 1'b1;
                    end
                end
                STALL: begin
                    if (!send_s) begin
                        state <= IDLE;
                        stall <= 1'b0;
                    end else if (!full) begin
                        state <= ACK_HI;
                        stall <= 1'b0;
                        ack   <= 1'b1;
                    end
                end
                ACK_HI: begin
                    if (!send_s) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    per_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst1  (rst1),
        .push  (push),
        .pop   (rd_en),
        .din   (dado),
        .dout  (rd_data),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign rd_valid = !empty;

endmodule

// File: tb/tb_periph_rx_handshake.sv
// Randomised bench for periph_rx_handshake against a queue model.
// CPU side is modelled as a four-phase sender waiting on ack.
module tb_periph_rx_handshake;

    localparam int DW    = 2;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int CW    = 8;

    logic          clk1 = 1'b0;
    logic          rst1 = 1'b1;
    logic [1:0]    send = 2'b00;
    logic [DW-1:0] dado = '0;
    logic          rd_en = 1'b0;
    logic          ack;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    fifo_count;
    logic          stall;
    logic [CW-1:0] rx_count;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] q[$];
    int            rx_model = 0;

    always #5 clk1 = ~clk1;

    periph_rx_handshake #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS),
        .CNT_W       (CW)
    ) dut (
        .clk1       (clk1),
        .rst1       (rst1),
        .send       (send),
        .dado       (dado),
        .ack        (ack),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .stall      (stall),
        .rx_count   (rx_count)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst1  = 1'b1;
        send  = 2'b00;
        rd_en = 1'b0;
        @(negedge clk1);
        rst1 = 1'b0;
        q.delete();
        rx_model = 0;
    endtask

    task automatic check_state(input string name);
        logic [DW-1:0] exp_head;
        exp_head = (q.size() != 0) ? q[0] : '0;
        checks++;
        if (fifo_count !== 3'(q.size()) || rx_count !== CW'(rx_model) ||
            rd_data !== exp_head || rd_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL %s: cnt=%0d rx=%0d head=%0d vld=%0b, expected cnt=%0d rx=%0d head=%0d vld=%0b",
                     name, fifo_count, rx_count, rd_data, rd_valid,
                     q.size(), CW'(rx_model), exp_head, q.size() != 0);
        end
    endtask

    // One complete CPU handshake; FIFO must not be full on entry
    task automatic hs(input logic [DW-1:0] d);
        int n;
        bit seen;
        dado = d;
        send = {1'($urandom), 1'b1};
        n = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (ack === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || n != SS + 1) begin
            errors++;
            $display("FAIL ack_rise: got %0d edges (seen=%0b), expected %0d", n, seen, SS + 1);
        end
        if (seen) begin
            q.push_back(d);
            rx_model++;
        end
        send = {1'($urandom), 1'b0};
        dado = DW'($urandom);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (ack === 1'b0) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || n != SS + 1) begin
            errors++;
            $display("FAIL ack_fall: got %0d edges (seen=%0b), expected %0d", n, seen, SS + 1);
        end
        check_state("hs_state");
    endtask

    task automatic pop1();
        logic [DW-1:0] exp_head;
        exp_head = (q.size() != 0) ? q[0] : '0;
        checks++;
        if (rd_data !== exp_head || rd_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL pop_head: data=%0d vld=%0b, expected data=%0d vld=%0b",
                     rd_data, rd_valid, exp_head, q.size() != 0);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        checks++;
        if (fifo_count !== 3'(q.size())) begin
            errors++;
            $display("FAIL pop_count: got %0d, expected %0d", fifo_count, q.size());
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || stall !== 1'b0 || rx_count !== '0 ||
            fifo_count !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_vals: ack=%0b stall=%0b rx=%0d cnt=%0d vld=%0b data=%0d, expected all 0",
                     ack, stall, rx_count, fifo_count, rd_valid, rd_data);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (ack !== 1'b0 || rd_valid !== 1'b0 || fifo_count !== '0 || rx_count !== '0) begin
                errors++;
                $display("FAIL idle_cycle%0d: ack=%0b vld=%0b cnt=%0d rx=%0d, expected all 0",
                         i, ack, rd_valid, fifo_count, rx_count);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        hs(2'b01);
        checks++;
        if (rd_data !== 2'b01 || fifo_count !== 3'd1 || rx_count !== 8'd1) begin
            errors++;
            $display("FAIL single: data=%0d cnt=%0d rx=%0d, expected 1 1 1",
                     rd_data, fifo_count, rx_count);
        end
    endtask

    task automatic test_fill_backpressure();
        bit seen;
        do_reset();
        for (int i = 0; i < DEPTH; i++) hs(DW'(i));
        dado = 2'b10;
        send = 2'b01;
        repeat (6) tick();
        checks++;
        if (stall !== 1'b1 || ack !== 1'b0 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL stall_hold: stall=%0b ack=%0b cnt=%0d, expected 1 0 4",
                     stall, ack, fifo_count);
        end
        checks++;
        if (rd_data !== q[0]) begin
            errors++;
            $display("FAIL stall_head: got %0d, expected %0d", rd_data, q[0]);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(q.pop_front());
        checks++;
        if (ack !== 1'b0 || stall !== 1'b1 || fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL pop_on_full: ack=%0b stall=%0b cnt=%0d, expected 0 1 3",
                     ack, stall, fifo_count);
        end
        tick();
        q.push_back(2'b10);
        rx_model++;
        checks++;
        if (ack !== 1'b1 || stall !== 1'b0 || fifo_count !== 3'd4 || rx_count !== 8'd5) begin
            errors++;
            $display("FAIL stall_accept: ack=%0b stall=%0b cnt=%0d rx=%0d, expected 1 0 4 5",
                     ack, stall, fifo_count, rx_count);
        end
        send = 2'b00;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack === 1'b0) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_release: ack stuck at %0b, expected 0", ack);
        end
        for (int i = 0; i < DEPTH; i++) pop1();
        check_state("fill_drained");
    endtask

    task automatic test_simul_push_pop();
        logic [DW-1:0] d;
        do_reset();
        hs(DW'($urandom));
        hs(DW'($urandom));
        d = DW'($urandom);
        dado = d;
        send = 2'b01;
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(q.pop_front());
        q.push_back(d);
        rx_model++;
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL simul_ack: got %0b, expected 1", ack);
        end
        check_state("simul_state");
        send = 2'b00;
        repeat (SS + 1) tick();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL simul_fall: got %0b, expected 0", ack);
        end
        pop1();
        pop1();
        check_state("simul_drained");
    endtask

    task automatic test_empty_pop_long_pulse();
        logic [DW-1:0] d;
        do_reset();
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        check_state("empty_pop");
        d = DW'($urandom);
        dado = d;
        send = 2'b01;
        repeat (50) tick();
        q.push_back(d);
        rx_model++;
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL long_ack: got %0b, expected 1", ack);
        end
        check_state("long_held");
        send = 2'b00;
        repeat (SS + 2) tick();
        check_state("long_done");
    endtask

    task automatic test_reset_mid_ack_wrap();
        do_reset();
        hs(DW'($urandom));
        dado = DW'($urandom);
        send = 2'b01;
        repeat (SS + 1) tick();
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ack: got %0b, expected 1", ack);
        end
        #2;
        rst1 = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || fifo_count !== '0 || rd_valid !== 1'b0 ||
            stall !== 1'b0 || rx_count !== '0) begin
            errors++;
            $display("FAIL async_reset: ack=%0b cnt=%0d vld=%0b stall=%0b rx=%0d, expected all 0",
                     ack, fifo_count, rd_valid, stall, rx_count);
        end
        send = 2'b00;
        @(negedge clk1);
        rst1 = 1'b0;
        q.delete();
        rx_model = 0;
        for (int i = 0; i < 256; i++) begin
            if (q.size() == DEPTH || $urandom_range(0, 1) == 1) pop1();
            hs(DW'($urandom));
        end
        checks++;
        if (rx_count !== 8'd0) begin
            errors++;
            $display("FAIL rx_wrap: got %0d, expected 0", rx_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_simul_push_pop();
        test_empty_pop_long_pulse();
        test_reset_mid_ack_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/periph_rx_handshake.md
Name: periph_rx_handshake

Overview:
- Peripheral-side receiver for the CPU-to-peripheral four-phase handshake. It consumes the CPU FSM's `send`/`dado` outputs and produces the `ack` the CPU FSM waits on.
- `send` arrives from the CPU clock domain and is synchronised into clk1. Each accepted `dado` word is queued in a small FIFO that local peripheral logic drains.
- When the FIFO is full, `ack` is withheld, which applies backpressure to the CPU.

Parameters:
- DATA_W, 2, width of `dado` and of each FIFO entry.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flop stages on `send`; at least 2.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk1  in  1  peripheral clock.
- rst1  in  1  asynchronous, active-high reset.
- send  in  2  CPU send strobe. Only send[0] is used (1 = data valid); send[1] is ignored.
- dado  in  DATA_W  CPU data; held stable by the CPU while send[0]=1.
- ack  out  1  handshake acknowledge to the CPU; registered.
- rd_en  in  1  local pop request.
- rd_data  out  DATA_W  FIFO head word; valid when rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.
- stall  out  1  high while a request is pending against a full FIFO.
- rx_count  out  CNT_W  total words accepted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, takes effect immediately, not on a clock edge):
  - ack=0, stall=0, rx_count=0, fifo_count=0, rd_valid=0, rd_data=0.
  - All sync flops cleared; FSM goes to IDLE.
- Synchroniser:
  - send_s is the last flop of a SYNC_STAGES chain fed by send[0].
  - `dado` is not synchronised. It is sampled raw on the accept edge; bundled-data rule: it is stable while send[0]=1.
- FSM states and encodings: IDLE=2'b00, ACK_HI=2'b01, STALL=2'b10. Encoding 2'b11 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - send_s=1 and FIFO not full: on that edge, push `dado`, increment rx_count, go to ACK_HI.
  - send_s=1 and FIFO full: go to STALL.
  - Otherwise stay in IDLE.
- STALL:
  - stall=1, ack=0.
  - When the FIFO becomes not full (full evaluated before that cycle's pop), push, increment rx_count and go to ACK_HI.
  - If send_s falls first, return to IDLE with no push.
- ACK_HI:
  - ack=1.
  - Stay while send_s=1. When send_s=0, go to IDLE; ack=0 from that edge.
- Outputs: ack and stall are Moore outputs, registered from state.
- Latency:
  - send[0] rising to ack rising: SYNC_STAGES+1 clk1 edges when the FIFO is not full.
  - send[0] falling to ack falling: SYNC_STAGES+1 edges.
- Exactly one push per send pulse. A long send pulse never causes a double-write.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - rd_data shows the head word combinationally from storage.
  - A pop with rd_en=1 and empty FIFO is ignored.
  - A push and pop in the same cycle leave fifo_count unchanged and keep the data order.
  - Full is judged before the pop, so a push is refused in the same cycle as a pop on a full FIFO and accepted on the next cycle.
- rx_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset during ACK_HI or STALL: ack drops immediately and FIFO contents are discarded. The CPU sees ack=0 and returns to its initial state.

Decomposition:
- Package periph_pkg:
  - State encoding constants IDLE, ACK_HI and STALL.
  - Default DATA_W and DEPTH.
- Sub-module per_fifo (parameters DATA_W, DEPTH):
  - Ports: push, pop, din, dout, count, full, empty.
  - Uses the same clk1/rst1.
- Synchroniser and FSM stay in the top module.

Test Plan:
- Reset then idle: rst1 pulse, send=0 for 10 cycles -> ack=0, rd_valid=0, fifo_count=0, rx_count=0 throughout.
- Single handshake: dado=2'b01, send=1 held until ack, then send=0 -> ack rises SYNC_STAGES+1=3 edges after send and falls 3 edges after send drops; rd_data=2'b01, fifo_count=1, rx_count=1.
- Fill and backpressure: 4 handshakes with dado=0,1,2,3 and no reads, then a 5th with dado=2'b10 -> the 5th stays in STALL with stall=1 and ack=0. Pop once -> the 5th is accepted one edge after the pop cycle, ack=1, pop order is 0,1,2,3 followed by 2.
- Simultaneous push/pop: fifo_count=2, rd_en=1 on the accept edge -> fifo_count stays 2 and the head advances correctly.
- Empty pop and long pulse: rd_en=1 with the FIFO empty -> no change. A send pulse 50 cycles long -> exactly one push, rx_count increments by 1.
- Reset mid-ACK_HI, then wrap: assert rst1 while ack=1 -> ack=0 asynchronously and fifo_count=0. Then 256 handshakes -> rx_count wraps to 0.
